// File: rtl/code_window_counter.sv
// Per-window histogram of 2-bit classification codes. The result is held
// behind a valid/ack handshake, and a sticky overrun flag marks dropped windows.
module code_window_counter #(
  parameter int unsigned window    = 1024,
  parameter int unsigned cnt_width = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 enable,
  input  logic                 sample_stb,
  input  logic [1:0]           code,
  output logic                 res_valid,
  input  logic                 res_ack,
  output logic [cnt_width-1:0] cnt_zero,
  output logic [cnt_width-1:0] cnt_a,
  output logic [cnt_width-1:0] cnt_b,
  output logic [cnt_width-1:0] cnt_other,
  output logic                 overrun,
  input  logic                 ovr_clr
);

  localparam logic [cnt_width-1:0] LAST = cnt_width'(window - 1);

  logic [cnt_width-1:0] r_acc [4];
  logic [cnt_width-1:0] r_scnt;
  logic [cnt_width-1:0] w_final [4];
  logic                 w_done;
  logic                 w_buf_free;

  assign w_done     = enable && sample_stb && (r_scnt == LAST);
  assign w_buf_free = !res_valid || res_ack;

  // Final counts include the completing sample itself.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      w_final[k] = r_acc[k];
      if (code == 2'(k)) w_final[k] = r_acc[k] + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned k = 0; k < 4; k++) r_acc[k] <= '0;
      r_scnt    <= '0;
      res_valid <= 1'b0;
      cnt_zero  <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      cnt_other <= '0;
      overrun   <= 1'b0;
    end else begin
      if (!enable || w_done) begin
        for (int unsigned k = 0; k < 4; k++) r_acc[k] <= '0;
        r_scnt <= '0;
      end else if (sample_stb) begin
        r_acc[code] <= w_final[code];
        r_scnt      <= r_scnt + 1'b1;
      end

      // A load on the ack edge keeps res_valid high with no gap.
      if (w_done && w_buf_free) begin
        res_valid <= 1'b1;
        cnt_zero  <= w_final[0];
        cnt_a     <= w_final[1];
        cnt_b     <= w_final[2];
        cnt_other <= w_final[3];
      end else if (res_valid && res_ack) begin
        res_valid <= 1'b0;
      end

      if (w_done && !w_buf_free) overrun <= 1'b1;
      else if (ovr_clr)          overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_code_window_counter.sv
// Directed bench for code_window_counter: window=4 and window=8 instances
// sharing clock and reset, with hand-computed expected results.
module tb_code_window_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        en4 = 1'b0, stb4 = 1'b0, ack4 = 1'b0, clr4 = 1'b0;
  logic [1:0]  code4 = 2'd0;
  logic        v4, ovr4;
  logic [15:0] z4, a4, b4, o4;

  logic        en8 = 1'b0, stb8 = 1'b0, ack8 = 1'b0, clr8 = 1'b0;
  logic [1:0]  code8 = 2'd0;
  logic        v8, ovr8;
  logic [15:0] z8, a8, b8, o8;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  code_window_counter #(.window(4), .cnt_width(16)) u_dut4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(en4), .sample_stb(stb4),
    .code(code4), .res_valid(v4), .res_ack(ack4), .cnt_zero(z4),
    .cnt_a(a4), .cnt_b(b4), .cnt_other(o4), .overrun(ovr4), .ovr_clr(clr4)
  );

  code_window_counter #(.window(8), .cnt_width(16)) u_dut8 (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(en8), .sample_stb(stb8),
    .code(code8), .res_valid(v8), .res_ack(ack8), .cnt_zero(z8),
    .cnt_a(a8), .cnt_b(b8), .cnt_other(o8), .overrun(ovr8), .ovr_clr(clr8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk4(input string tag, input logic v, input logic [15:0] z,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
    chk({tag, ".valid"}, 32'(v4), 32'(v));
    chk({tag, ".zero"},  32'(z4), 32'(z));
    chk({tag, ".a"},     32'(a4), 32'(a));
    chk({tag, ".b"},     32'(b4), 32'(b));
    chk({tag, ".other"}, 32'(o4), 32'(o));
  endtask

  task automatic send4(input logic [1:0] c);
    stb4 = 1'b1; code4 = c;
    step();
    stb4 = 1'b0;
  endtask

  task automatic send8_gapped(input logic [1:0] c);
    stb8 = 1'b1; code8 = c;
    step();
    stb8 = 1'b0;
    step();
    step();
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    #2;
    chk4("rst", 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    chk("rst.ovr", 32'(ovr4), 32'd0);
    chk("rst.v8", 32'(v8), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // window=4: one of each code back to back
    en4 = 1'b1;
    send4(2'b00); send4(2'b01); send4(2'b10);
    chk("t1.pre_valid", 32'(v4), 32'd0);
    send4(2'b11);
    chk4("t1", 1'b1, 16'd1, 16'd1, 16'd1, 16'd1);
    ack4 = 1'b1; step(); ack4 = 1'b0;
    chk("t1.acked", 32'(v4), 32'd0);

    // window=8, gapped strobes, no ack
    en8 = 1'b1;
    for (int i = 0; i < 5; i++) send8_gapped(2'b01);
    send8_gapped(2'b11); send8_gapped(2'b11);
    chk("t2.pre_valid", 32'(v8), 32'd0);
    stb8 = 1'b1; code8 = 2'b11; step(); stb8 = 1'b0;
    chk("t2.valid", 32'(v8), 32'd1);
    chk("t2.a", 32'(a8), 32'd5);
    chk("t2.other", 32'(o8), 32'd3);
    chk("t2.zero", 32'(z8), 32'd0);
    chk("t2.b", 32'(b8), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("t2.hold_valid", 32'(v8), 32'd1);
    chk("t2.hold_a", 32'(a8), 32'd5);
    chk("t2.hold_other", 32'(o8), 32'd3);

    // Held result, then a dropped window sets overrun
    send4(2'b01); send4(2'b01); send4(2'b10); send4(2'b10);
    chk4("t3.held", 1'b1, 16'd0, 16'd2, 16'd2, 16'd0);
    chk("t3.ovr0", 32'(ovr4), 32'd0);
    for (int i = 0; i < 4; i++) send4(2'b10);
    chk4("t3.drop", 1'b1, 16'd0, 16'd2, 16'd2, 16'd0);
    chk("t3.ovr1", 32'(ovr4), 32'd1);
    // Set and clear in the same cycle: set wins
    send4(2'b11); send4(2'b11); send4(2'b11);
    clr4 = 1'b1; send4(2'b11); clr4 = 1'b0;
    chk("t3.set_wins", 32'(ovr4), 32'd1);
    chk4("t3.drop2", 1'b1, 16'd0, 16'd2, 16'd2, 16'd0);
    clr4 = 1'b1; step(); clr4 = 1'b0;
    chk("t3.cleared", 32'(ovr4), 32'd0);

    // Ack coinciding with completion: no gap, new result loads
    send4(2'b00); send4(2'b00); send4(2'b00);
    ack4 = 1'b1; send4(2'b00); ack4 = 1'b0;
    chk4("t4", 1'b1, 16'd4, 16'd0, 16'd0, 16'd0);
    chk("t4.ovr", 32'(ovr4), 32'd0);
    ack4 = 1'b1; step(); ack4 = 1'b0;
    chk("t4.acked", 32'(v4), 32'd0);

    // Partial window discarded by dropping enable
    send4(2'b10); send4(2'b10); send4(2'b10);
    en4 = 1'b0;
    send4(2'b00); send4(2'b00);
    en4 = 1'b1;
    send4(2'b01);
    chk("t5.no_early", 32'(v4), 32'd0);
    send4(2'b01); send4(2'b01); send4(2'b01);
    chk4("t5", 1'b1, 16'd0, 16'd4, 16'd0, 16'd0);
    ack4 = 1'b1; step(); ack4 = 1'b0;

    // Async reset mid-window with a held result and overrun set
    for (int i = 0; i < 4; i++) send4(2'b10);
    for (int i = 0; i < 4; i++) send4(2'b00);
    chk("t6.ovr_pre", 32'(ovr4), 32'd1);
    send4(2'b01); send4(2'b01);
    rst_n = 1'b0;
    #2;
    chk4("t6.rst", 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    chk("t6.rst_ovr", 32'(ovr4), 32'd0);
    chk("t6.rst_v8", 32'(v8), 32'd0);
    chk("t6.rst_a8", 32'(a8), 32'd0);
    rst_n = 1'b1;
    send4(2'b11); send4(2'b11); send4(2'b11);
    chk("t6.pre_valid", 32'(v4), 32'd0);
    send4(2'b11);
    chk4("t6", 1'b1, 16'd0, 16'd0, 16'd0, 16'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/code_window_counter.md
# code_window_counter

Downstream consumer of `coder_vector` in the sampling core. Each cycle `sample_stb` is high, the block takes one 2-bit classification code and counts it in one of four classes: zero, pattern A, pattern B, other. After `window` strobes it publishes all four counts as one result. The result is held behind a valid/ack handshake for the bus-side reader, so the monitor gets a per-window histogram of observed patterns instead of raw samples.

## Interface
Parameters:
- `window`, default 1024: samples per window. Legal range is 1 ≤ `window` ≤ 2^`cnt_width` − 1.
- `cnt_width`, default 16: width of each count output and of the internal sample counter.

Ports:
- `sys_clk` input, 1 bit: the single clock. Everything is rising-edge.
- `sys_rst_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: 1 = count. 0 = hold off and discard the partial window.
- `sample_stb` input, 1 bit: `code` is valid this cycle.
- `code` input, 2 bits: class of the sample. 00 = zero, 01 = pattern A, 10 = pattern B, 11 = other.
- `res_valid` output, 1 bit: a result is held in the output registers.
- `res_ack` input, 1 bit: the reader consumes the result.
- `cnt_zero`, `cnt_a`, `cnt_b`, `cnt_other` outputs, `cnt_width` bits each: counts from the last published window.
- `overrun` output, 1 bit: sticky flag. A completed window was dropped because the previous result had not been acked.
- `ovr_clr` input, 1 bit: clears `overrun`.

## Operation
- Internal state:
  - Four accumulators `acc[0..3]`, each `cnt_width` bits.
  - Sample counter `scnt`, `cnt_width` bits.
  - Output registers and `res_valid`.
  - `overrun`.
- States:
  - IDLE (`enable`=0): accumulators and `scnt` are forced to 0 each cycle. Strobes are ignored. The held result and `overrun` are kept.
  - COUNT (`enable`=1): on `sample_stb`=1, `acc[code]` += 1 and `scnt` += 1.
- Window completion is a cycle with `enable`=1, `sample_stb`=1 and `scnt` == `window`−1.
  - Final counts include the current sample.
  - If the output buffer is free, the counts are copied to the `cnt_*` outputs and `res_valid` is set. The buffer is free when `res_valid`=0, or when `res_valid`=1 and `res_ack`=1 in the same cycle.
  - If the buffer is not free, the counts are discarded, `overrun` is set, and the outputs keep the old result.
  - In both cases accumulators and `scnt` return to 0, so the next strobe starts a new window.
- Handshake:
  - `res_valid` stays high until it is high in the same cycle as `res_ack`.
  - `res_ack` while `res_valid`=0 has no effect.
  - The `cnt_*` outputs change only on a load.
- Simultaneous ack and completion: the new result loads and `res_valid` stays 1 with no gap.
- `overrun` and `ovr_clr`:
  - `ovr_clr` clears `overrun`.
  - If a set event and `ovr_clr` occur in the same cycle, the set wins.
- Invariant: `cnt_zero`+`cnt_a`+`cnt_b`+`cnt_other` == `window` for every published result. No accumulator can overflow within the legal parameter range.
- `window`=1: every accepted strobe completes a window, and exactly one count is 1.
- Async reset: all outputs and all internal state go to 0 immediately.
  - A reset mid-window loses the partial window.
  - A reset while `res_valid`=1 drops the held result.

## Timing
- Reset values: `res_valid`=0, `overrun`=0, and all `cnt_*`=0.
- Accumulation takes effect one cycle after the strobe.
- Result latency: `res_valid` and the new `cnt_*` appear on the edge that samples the final strobe, so they are visible in the next cycle.
- `res_valid` falls one cycle after the ack edge unless a new load happens on that same edge.
- Falling `enable`: the partial window is cleared at the next edge. A strobe in a cycle with `enable`=0 is not counted.
- `overrun` is set one cycle after the dropped completion. It is cleared one cycle after `ovr_clr`.
- Throughput: one sample per cycle with no stalls. No backpressure is applied to `sample_stb`.

## Test plan
- Reset, then `window`=4 with codes 00,01,10,11 on 4 back-to-back strobes → `res_valid`=1 in the cycle after the 4th strobe, with `cnt_zero`=`cnt_a`=`cnt_b`=`cnt_other`=1.
- `window`=8 with strobes gapped every 3 cycles, 5×01 then 3×11, `res_ack` held 0 → result `cnt_a`=5, `cnt_other`=3, `cnt_zero`=`cnt_b`=0. `res_valid` stays high with outputs stable.
- With a result held and unacked, complete a second window of 4×10 → `overrun`=1 and outputs unchanged. Pulse `ovr_clr` → `overrun`=0 next cycle.
- Assert `res_ack` in the same cycle as the completing strobe of 4×00 → `cnt_zero`=4 and `res_valid` remains 1 with no gap.
- Send 3 strobes, drop `enable` for 2 cycles with strobes present, re-enable, then send 4×01 → one result, `cnt_a`=4 and all other counts 0.
- Assert `sys_rst_n`=0 mid-window while `res_valid`=1 → all outputs are 0 immediately. After release, a full window of 4×11 gives `cnt_other`=4.
